// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer/status block for the async FIFO: binary/gray read pointers,
// look-ahead empty, fill level, almost-empty, sticky underflow and read-data-valid.
module rptr_empty_lvl #(
    parameter int unsigned ADDRSIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [ADDRSIZE:0]   rae_thresh,
    input  logic                rclr_err,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rdvalid,
    output logic                runderflow
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          rpop;

    // Look-ahead pointer and level: status already accounts for this cycle's pop.
    always_comb begin
        rpop       = rinc & ~rempty;
        rbinnext   = rbin + PW'(rpop);
        rgraynext  = (rbinnext >> 1) ^ rbinnext;
        wbin       = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
        level_next = wbin - rbinnext;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            rdvalid    <= 1'b0;
            runderflow <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            rlevel  <= level_next;
            raempty <= (level_next <= rae_thresh);
            rdvalid <= rpop;
            // Set has priority over clear so a coincident underflow is never lost.
            if (rinc & rempty) begin
                runderflow <= 1'b1;
            end else if (rclr_err) begin
                runderflow <= 1'b0;
            end
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule
